// File: rtl/spi_slave_wb8_pkg.sv
// spi_slave_wb8_pkg: register map, STATUS/CTRL bit indices and RX FIFO depth
package spi_slave_wb8_pkg;
  localparam logic [1:0] ADR_DATA = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL = 2'd2;
  localparam logic [1:0] ADR_RSVD = 2'd3;
  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_TX_UNDERRUN = 3;
  localparam int ST_CS_ACTIVE = 4;
  localparam int CTRL_IRQ_EN = 0;
  localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: 2-FF synchronizer with rise/fall detection on the synchronized level
module spi_slave_sync #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= {3{INIT}};
    else s <= {s[1:0], d};
  end
  assign q = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_slave_wb8.sv
// spi_slave_wb8: SPI mode-0 slave with 8-bit Wishbone registers.
// Define SPI_SLAVE_RXFIFO_EN for a 4-entry RX FIFO; otherwise a single RX holding register.
module spi_slave_wb8 (
  input  logic       I_wb_clk,
  input  logic       I_reset_n,
  input  logic [1:0] I_wb_adr,
  input  logic [7:0] I_wb_dat,
  input  logic       I_wb_stb,
  input  logic       I_wb_we,
  output logic [7:0] O_wb_dat,
  output logic       O_wb_ack,
  input  logic       I_spi_sck,
  input  logic       I_spi_cs_n,
  input  logic       I_spi_mosi,
  output logic       O_spi_miso,
  output logic       O_spi_miso_oe,
  output logic       O_interrupt
);
  import spi_slave_wb8_pkg::*;
`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int D = FIFO_DEPTH;
`else
  localparam int D = 1;
`endif
  localparam int CW = $clog2(D + 1);
  logic sck_unused, sck_rise, sck_fall, cs_n, cs_rise, cs_fall;
  logic [1:0] mosi_s;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr, tx_sr, txdata, rdata, status, ctrl, rx_byte;
  logic [7:0] q [D];
  logic [CW-1:0] cnt, widx;
  logic tx_full, tx_underrun, rx_overrun, irq_en;
  logic cs_active, acc, wr, rd, wr_data, w1c_ov, w1c_un, byte_done, load, pop, push_ok, rx_valid;
  spi_slave_sync u_sck (.clk(I_wb_clk), .rst_n(I_reset_n), .d(I_spi_sck), .q(sck_unused), .rise(sck_rise), .fall(sck_fall));
  spi_slave_sync #(.INIT(1'b1)) u_cs (.clk(I_wb_clk), .rst_n(I_reset_n), .d(I_spi_cs_n), .q(cs_n), .rise(cs_rise), .fall(cs_fall));
  always_comb begin
    cs_active = ~cs_n;
    acc = I_wb_stb & ~O_wb_ack;
    wr = acc & I_wb_we;
    rd = acc & ~I_wb_we;
    wr_data = wr & (I_wb_adr == ADR_DATA);
    w1c_ov = wr & (I_wb_adr == ADR_STATUS) & I_wb_dat[ST_RX_OVERRUN];
    w1c_un = wr & (I_wb_adr == ADR_STATUS) & I_wb_dat[ST_TX_UNDERRUN];
    rx_byte = {rx_sr[6:0], mosi_s[1]};
    byte_done = sck_rise & cs_active & (bit_cnt == 3'd7);
    load = cs_fall | byte_done;
    rx_valid = cnt != '0;
    pop = rd & (I_wb_adr == ADR_DATA) & rx_valid;
    push_ok = byte_done & ((cnt != CW'(D)) | pop);
    widx = pop ? cnt - 1'b1 : cnt;
    status = '0;
    status[ST_RX_VALID] = rx_valid;
    status[ST_TX_FULL] = tx_full;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_TX_UNDERRUN] = tx_underrun;
    status[ST_CS_ACTIVE] = cs_active;
    ctrl = '0;
    ctrl[CTRL_IRQ_EN] = irq_en;
    rdata = I_wb_adr == ADR_DATA ? (rx_valid ? q[0] : 8'h00) :
            I_wb_adr == ADR_STATUS ? status :
            I_wb_adr == ADR_CTRL ? ctrl : 8'h00;
  end
  // The falling edge right after a byte boundary is not shifted, so the reloaded MSB is what the master sees first.
  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      mosi_s <= '0;
      bit_cnt <= '0;
      rx_sr <= '0;
      tx_sr <= '0;
      txdata <= '0;
      tx_full <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun <= 1'b0;
      irq_en <= 1'b0;
      cnt <= '0;
      O_wb_ack <= 1'b0;
      O_wb_dat <= '0;
      for (int i = 0; i < D; i++) q[i] <= '0;
    end else begin
      mosi_s <= {mosi_s[0], I_spi_mosi};
      O_wb_ack <= acc;
      O_wb_dat <= rd ? rdata : 8'h00;
      bit_cnt <= (cs_fall | cs_rise) ? 3'd0 : (sck_rise & cs_active) ? bit_cnt + 3'd1 : bit_cnt;
      if (sck_rise & cs_active) rx_sr <= rx_byte;
      if (load) tx_sr <= tx_full ? txdata : 8'h00;
      else if (sck_fall & cs_active & (bit_cnt != 3'd0)) tx_sr <= {tx_sr[6:0], 1'b0};
      if (wr_data) txdata <= I_wb_dat;
      tx_full <= wr_data | (tx_full & ~load);
      tx_underrun <= (load & ~tx_full) | (tx_underrun & ~w1c_un);
      rx_overrun <= (byte_done & ~push_ok) | (rx_overrun & ~w1c_ov);
      if (wr & (I_wb_adr == ADR_CTRL)) irq_en <= I_wb_dat[CTRL_IRQ_EN];
      cnt <= cnt + CW'(push_ok) - CW'(pop);
      for (int i = 0; i < D; i++) begin
        if (pop) q[i] <= q[(i + 1) % D];
        if (push_ok && CW'(i) == widx) q[i] <= rx_byte;
      end
    end
  end
  assign O_spi_miso = tx_sr[7];
  assign O_spi_miso_oe = cs_active;
  assign O_interrupt = irq_en & rx_valid;
endmodule
